// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the lowpass FIR and the decimator that
// follows it.
//   SAMPLE_W  : sample width in bits
//   sample_t  : signed sample type
//   DECIM_DEF : default decimation ratio
//   DEPTH_DEF : default output FIFO depth
package fir_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int DECIM_DEF = 4;
    localparam int DEPTH_DEF = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo -- synchronous show-ahead FIFO of sample_t.
//   clk, n_rst : clock, asynchronous active-low reset
//   push/wdata : write request and data
//   pop        : read request (ignored when empty)
//   rdata      : head entry, valid whenever empty=0
//   full/empty : occupancy flags
//   count      : occupancy 0..DEPTH
// A push while full is accepted only if a pop happens on the same edge;
// otherwise it is dropped and the contents are left untouched.
module sample_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  sample_t                wdata,
    input  logic                   pop,
    output sample_t                rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being vacated by the pop is the one written.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// fir_decimator -- keeps one of every DECIM valid FIR samples (or their
// floor mean) and queues the result in an output FIFO.
//   clk, n_rst  : clock, asynchronous active-low reset
//   din         : signed FIR output sample, qualified by din_valid
//   dout        : FIFO head, forced to 0 while dout_valid=0
//   dout_valid  : FIFO non-empty; dout_ready pops on the same edge
//   fifo_count  : FIFO occupancy
//   overflow    : sticky, set when a decimated sample is dropped;
//                 clr_ovf clears it (a simultaneous drop wins)
// Build option: define FIR_DECIM_AVG_EN to emit the floor mean of each
// group of DECIM samples instead of the last sample of the group.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic signed [SAMPLE_W-1:0]  din,
    input  logic                        din_valid,
    output logic signed [SAMPLE_W-1:0]  dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        overflow,
    input  logic                        clr_ovf
);

    localparam int              PH_W    = $clog2(DECIM);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0] phase;
    logic            emit;
    logic            pop;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    sample_t         emit_val;
    sample_t         fifo_rdata;

    assign emit = din_valid && (phase == PH_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= '0;
        end else if (din_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

`ifdef FIR_DECIM_AVG_EN
    // Group sum needs PH_W extra bits; the mean always fits SAMPLE_W again.
    localparam int ACC_W = SAMPLE_W + PH_W;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] acc_sum;

    assign din_ext  = $signed({{PH_W{din[SAMPLE_W-1]}}, din});
    assign acc_sum  = acc + din_ext;
    // Arithmetic shift gives floor of the mean for negative sums too.
    assign emit_val = sample_t'(acc_sum >>> PH_W);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc <= '0;
        end else if (din_valid) begin
            acc <= (phase == '0) ? din_ext : acc_sum;
        end
    end
`else
    assign emit_val = din;
`endif

    assign dout_valid = !fifo_empty;
    assign dout       = fifo_empty ? '0 : fifo_rdata;
    assign pop        = dout_valid && dout_ready;
    assign drop       = emit && fifo_full && !pop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (emit),
        .wdata (emit_val),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
